// File: rtl/gsensor_spi_responder.sv
// -----------------------------------------------------------------------------
// gsensor_spi_responder
//   SPI mode-3 slave that stands in for the 3-axis accelerometer on the
//   gsensor_* bus. Decodes an ADXL345-style command byte and serves a 64 x 8
//   register file:
//     0x00        DEVID (read-only)
//     0x32..0x37  X0,X1,Y0,Y1,Z0,Z1 from accel_* (read-only, low byte first)
//     others      RAM, cleared by reset
//   Accepted writes are reported to local logic on reg_wr_*.
//
// Ports
//   clk_clk, reset_reset_n      system clock, async active-low reset
//   gsensor_SCLK/MOSI/SS_n      SPI inputs (asynchronous to clk_clk)
//   gsensor_MISO, _MISO_oe      SPI output and pad drive enable
//   accel_x/y/z, accel_valid    signed samples and their load strobe
//   reg_wr_strobe/addr/data     one-cycle report of each accepted write byte
//   xfer_active                 synchronized slave select is asserted
//
// Configuration
//   GSENSOR_SPI_SNAPSHOT_EN  when defined, samples arriving during a transfer
//                            are held in a pending buffer and published one
//                            cycle after SS_n deasserts, so a burst read of
//                            X0..Z1 is coherent.
// -----------------------------------------------------------------------------
module gsensor_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        gsensor_SCLK,
  input  logic        gsensor_MOSI,
  input  logic        gsensor_SS_n,
  output logic        gsensor_MISO,
  output logic        gsensor_MISO_oe,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  input  logic        accel_valid,
  output logic        reg_wr_strobe,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        xfer_active
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers, reset to the bus idle levels.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_prev, ss_prev;
  // Marks when ss_prev/ss_s both hold real pin samples, so a slave select that
  // is already low when reset releases is not mistaken for a new falling edge.
  logic [SYNC_STAGES:0]   fill_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
      fill_q    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], gsensor_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], gsensor_MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], gsensor_SS_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      ss_prev   <= ss_sync[SYNC_STAGES-1];
      fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s, mosi_s, ss_s;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  logic sclk_rise, sclk_fall, ss_active, ss_fall;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign ss_active = ~ss_s;
  assign ss_fall   = ss_prev & ~ss_s & fill_q[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_in, shift_out, rx_byte;
  logic        rw_q, mb_q, miso_q;
  logic [5:0]  addr_q;
  logic        in_xfer, byte_done, is_data, writable, wr_en;

  assign in_xfer   = (state_q != ST_IDLE) && ss_active;
  assign rx_byte   = {shift_in[6:0], mosi_s};
  assign byte_done = in_xfer && sclk_rise && (bit_cnt == 3'd7);
  assign is_data   = (addr_q >= 6'h32) && (addr_q <= 6'h37);
  assign writable  = (addr_q != 6'h00) && !is_data;
  assign wr_en     = byte_done && (state_q == ST_DATA) && !rw_q && writable;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_CMD;
      ST_CMD:  if (byte_done) state_d = ST_DATA;
      ST_DATA: state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
    if (!ss_active) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [7:0] ram        [64];
  logic [7:0] data_reg   [6];
  logic [7:0] sample_bytes [6];
  logic [7:0] rd_data;
  logic [2:0] data_idx;

  assign data_idx = 3'(addr_q - 6'h32);

  always_comb begin
    sample_bytes[0] = accel_x[7:0];
    sample_bytes[1] = accel_x[15:8];
    sample_bytes[2] = accel_y[7:0];
    sample_bytes[3] = accel_y[15:8];
    sample_bytes[4] = accel_z[7:0];
    sample_bytes[5] = accel_z[15:8];
  end

  always_comb begin
    rd_data = ram[addr_q];
    if (addr_q == 6'h00) rd_data = DEVID;
    else if (is_data)    rd_data = data_reg[data_idx];
  end

  // NOTE: the RAM is reset explicitly because software relies on reading 0x00
  // from never-written registers; this forces it into flops rather than a
  // block RAM, which is acceptable at 64 bytes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (wr_en) begin
      ram[addr_q] <= rx_byte;
    end
  end

`ifdef GSENSOR_SPI_SNAPSHOT_EN
  logic [7:0] pend [6];
  logic       pend_valid;
  logic       ss_rise;
  assign ss_rise = ~ss_prev & ss_s;

  // A direct load also clears the pending flag: it is newer than anything
  // held, and must not be overwritten by a stale copy at the next SS_n rise.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 6; i++) begin
        data_reg[i] <= '0;
        pend[i]     <= '0;
      end
      pend_valid <= 1'b0;
    end else if (accel_valid && xfer_active) begin
      for (int i = 0; i < 6; i++) pend[i] <= sample_bytes[i];
      pend_valid <= 1'b1;
    end else if (accel_valid) begin
      for (int i = 0; i < 6; i++) data_reg[i] <= sample_bytes[i];
      pend_valid <= 1'b0;
    end else if (ss_rise && pend_valid) begin
      for (int i = 0; i < 6; i++) data_reg[i] <= pend[i];
      pend_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 6; i++) data_reg[i] <= '0;
    end else if (accel_valid) begin
      for (int i = 0; i < 6; i++) data_reg[i] <= sample_bytes[i];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Shift datapath, address sequencing and write reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt       <= '0;
      shift_in      <= '0;
      shift_out     <= '0;
      miso_q        <= 1'b0;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      addr_q        <= '0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      reg_wr_data   <= '0;
    end else begin
      reg_wr_strobe <= wr_en;
      if (wr_en) begin
        reg_wr_addr <= addr_q;
        reg_wr_data <= rx_byte;
      end

      if (!in_xfer) begin
        // Covers both idle and an SS_n rise mid-byte: partial bits are lost.
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        if (sclk_rise) begin
          shift_in <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state_q == ST_CMD) begin
              rw_q   <= rx_byte[7];
              mb_q   <= rx_byte[6];
              addr_q <= rx_byte[5:0];
            end else if (mb_q) begin
              addr_q <= addr_q + 6'd1;
            end
          end
        end
        // bit_cnt == 0 on a fall means a byte boundary was just crossed, so
        // the next byte is fetched and its MSB driven straight away.
        if (sclk_fall && (state_q == ST_DATA) && rw_q) begin
          if (bit_cnt == 3'd0) begin
            miso_q    <= rd_data[7];
            shift_out <= {rd_data[6:0], 1'b0};
          end else begin
            miso_q    <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign gsensor_MISO_oe = (state_q == ST_DATA) && rw_q;
  assign gsensor_MISO    = miso_q & gsensor_MISO_oe;
  assign xfer_active     = ss_active;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_gsensor_spi_responder
//   Drives SPI mode-3 transactions into gsensor_spi_responder and compares
//   read bytes, write reports, MISO enable and xfer_active against a
//   register-map model built from arrays and the command-byte rules.
// -----------------------------------------------------------------------------
module tb_gsensor_spi_responder;

  localparam int HALF = 8;  // clk cycles per SCLK phase

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso, miso_oe;
  logic [15:0] accel_x = '0, accel_y = '0, accel_z = '0;
  logic        accel_valid = 1'b0;
  logic        reg_wr_strobe;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        xfer_active;

  always #5 clk = ~clk;

  gsensor_spi_responder dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .gsensor_SCLK    (sclk),
    .gsensor_MOSI    (mosi),
    .gsensor_SS_n    (ss_n),
    .gsensor_MISO    (miso),
    .gsensor_MISO_oe (miso_oe),
    .accel_x         (accel_x),
    .accel_y         (accel_y),
    .accel_z         (accel_z),
    .accel_valid     (accel_valid),
    .reg_wr_strobe   (reg_wr_strobe),
    .reg_wr_addr     (reg_wr_addr),
    .reg_wr_data     (reg_wr_data),
    .xfer_active     (xfer_active)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register map as arrays plus current sample values.
  // ---------------------------------------------------------------------------
  typedef struct packed { logic [5:0] a; logic [7:0] d; } wr_t;

  logic [7:0]  m_mem [64];
  logic [15:0] m_ax, m_ay, m_az;
  wr_t         exp_wr [$];
  wr_t         got_wr [$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];
  logic [7:0]  ebuf [8];

  function automatic bit m_is_data(input int a);
    return (a >= 'h32) && (a <= 'h37);
  endfunction

  function automatic logic [7:0] m_read(input int a);
    logic [15:0] s;
    int idx;
    if (a == 0) return 8'hE5;
    if (m_is_data(a)) begin
      idx = a - 'h32;
      s = (idx / 2 == 0) ? m_ax : (idx / 2 == 1) ? m_ay : m_az;
      return (idx % 2 == 1) ? s[15:8] : s[7:0];
    end
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_ax = '0; m_ay = '0; m_az = '0;
  endtask

  // Expected bytes / writes for one transaction; pulse_after = byte index
  // after which a new sample arrives (-1 for none).
  task automatic model_txn(input logic [7:0] cmd, input int nbytes, input int pulse_after,
                           input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz);
    int a;
    wr_t w;
    a = int'(cmd[5:0]);
    for (int b = 0; b < nbytes; b++) begin
      if (cmd[7]) ebuf[b] = m_read(a);
      else if (a != 0 && !m_is_data(a)) begin
        m_mem[a] = wbuf[b];
        w.a = 6'(a); w.d = wbuf[b];
        exp_wr.push_back(w);
      end
`ifndef GSENSOR_SPI_SNAPSHOT_EN
      if (b == pulse_after) begin m_ax = px; m_ay = py; m_az = pz; end
`endif
      if (cmd[6]) a = (a + 1) % 64;
    end
`ifdef GSENSOR_SPI_SNAPSHOT_EN
    if (pulse_after >= 0) begin m_ax = px; m_ay = py; m_az = pz; end
`endif
  endtask

  // Write-report monitor
  always @(negedge clk) begin
    wr_t w;
    if (reg_wr_strobe === 1'b1) begin
      w.a = reg_wr_addr; w.d = reg_wr_data;
      got_wr.push_back(w);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus drivers
  // ---------------------------------------------------------------------------
  task automatic set_accel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    accel_x = x; accel_y = y; accel_z = z; accel_valid = 1'b1;
    @(negedge clk);
    accel_valid = 1'b0;
    m_ax = x; m_ay = y; m_az = z;
  endtask

  // MOSI changes with the SCLK fall; oe is sampled just before each rise,
  // MISO just before each fall.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    rx = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      oe_any = oe_any | miso_oe;
      oe_all = oe_all & miso_oe;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso};
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int nbytes, input int pulse_after,
                         input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz);
    logic [7:0] rx;
    logic any, all;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check("xfer_active_hi", xfer_active, 1);
    spi_bits(cmd, 8, rx, any, all);
    check("cmd_oe", any, 0);
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(wbuf[b], 8, rbuf[b], any, all);
      if (cmd[7]) check("rd_oe", all, 1);
      else        check("wr_oe", any, 0);
      if (b == pulse_after) begin
        accel_x = px; accel_y = py; accel_z = pz; accel_valid = 1'b1;
        @(negedge clk);
        accel_valid = 1'b0;
      end
    end
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("xfer_active_lo", xfer_active, 0);
    check("idle_oe", miso_oe, 0);
    check("idle_miso", miso, 0);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int nbytes, input int pulse_after,
                         input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz);
    int base;
    base = got_wr.size();
    exp_wr.delete();
    model_txn(cmd, nbytes, pulse_after, px, py, pz);
    spi_txn(cmd, nbytes, pulse_after, px, py, pz);
    if (cmd[7]) begin
      for (int b = 0; b < nbytes; b++) check("rd_byte", {cmd, 8'(b), rbuf[b]}, {cmd, 8'(b), ebuf[b]});
    end
    check("wr_count", got_wr.size() - base, exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (base + i < got_wr.size()) begin
        check("wr_addr", got_wr[base+i].a, exp_wr[i].a);
        check("wr_data", got_wr[base+i].d, exp_wr[i].d);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] exp_burst [6];

  initial begin
    logic [7:0] rx;
    logic any, all;
    logic [7:0] cmd;
    int nb, pa, base;

    m_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_strobe", reg_wr_strobe, 0);
    check("rst_wr_addr", reg_wr_addr, 0);
    check("rst_wr_data", reg_wr_data, 0);
    check("rst_xfer", xfer_active, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // DEVID single read
    wbuf[0] = 8'h00;
    run_txn(8'h80, 1, -1, '0, '0, '0);
    check("devid", rbuf[0], 8'hE5);

    // Multi-byte read of the sample registers
    set_accel(16'h1234, 16'hFF80, 16'h0100);
    for (int b = 0; b < 6; b++) wbuf[b] = 8'h00;
    run_txn(8'hF2, 6, -1, '0, '0, '0);
    exp_burst = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
    for (int b = 0; b < 6; b++) check("burst_lit", rbuf[b], exp_burst[b]);

    // Write with strobe, then read back
    wbuf[0] = 8'h08;
    run_txn(8'h2D, 1, -1, '0, '0, '0);
    wbuf[0] = 8'h00;
    run_txn(8'hAD, 1, -1, '0, '0, '0);
    check("rdback_2d", rbuf[0], 8'h08);

    // Multi-byte write wrapping 0x3F -> 0x00 (read-only)
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    run_txn(8'h7F, 2, -1, '0, '0, '0);
    wbuf[0] = 8'h00;
    run_txn(8'hBF, 1, -1, '0, '0, '0);
    check("rdback_3f", rbuf[0], 8'hAA);
    run_txn(8'h80, 1, -1, '0, '0, '0);
    check("devid_after_wrap", rbuf[0], 8'hE5);

    // Abort: SS_n rises after 4 bits of a data byte
    base = got_wr.size();
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h2D, 8, rx, any, all);
    spi_bits(8'h55, 4, rx, any, all);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_strobe", got_wr.size() - base, 0);
    check("abort_oe", miso_oe, 0);
    run_txn(8'hAD, 1, -1, '0, '0, '0);
    check("abort_keep", rbuf[0], 8'h08);

    // New sample arriving after byte 0 of a burst read
    for (int b = 0; b < 6; b++) wbuf[b] = 8'h00;
    run_txn(8'hF2, 6, 0, 16'h5555, 16'hAAAA, 16'hBBBB);
    run_txn(8'hB2, 1, -1, '0, '0, '0);
    check("sample_after", rbuf[0], 8'h55);

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0)
        set_accel(16'($urandom), 16'($urandom), 16'($urandom));
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) cmd[5:0] = 6'(8'h30 + $urandom_range(0, 8));
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) wbuf[b] = 8'($urandom);
      pa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_txn(cmd, nb, pa, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Reset in the middle of a write, SS_n held low across it
    base = got_wr.size();
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h05, 8, rx, any, all);
    spi_bits(8'h77, 4, rx, any, all);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check("midrst_oe", miso_oe, 0);
    check("midrst_strobe", reg_wr_strobe, 0);
    check("midrst_wr_data", reg_wr_data, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_bits(8'h06, 8, rx, any, all);
    spi_bits(8'h42, 8, rx, any, all);
    check("midrst_ignored_oe", any, 0);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_strobe", got_wr.size() - base, 0);
    wbuf[0] = 8'h00;
    run_txn(8'h86, 1, -1, '0, '0, '0);
    check("midrst_06", rbuf[0], 8'h00);
    run_txn(8'hB2, 1, -1, '0, '0, '0);
    check("midrst_x0", rbuf[0], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

- SPI slave that emulates the on-board 3-axis accelerometer at the far end of the `gsensor_*` 4-wire SPI bus.
- Lets the system's SPI master be exercised in simulation and on hardware loopback without the physical sensor.
- Decodes the ADXL345-style command byte and serves a 64 × 8 register file.
- Presents X/Y/Z samples from fabric inputs at the data registers, and reports register writes to local logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on SCLK/MOSI/SS_n (≥2)
- `DEVID`, 8'hE5: value returned at address 0x00

Ports:
- `clk_clk` in 1: system clock; all logic on rising edge
- `reset_reset_n` in 1: asynchronous, active-low reset
- `gsensor_SCLK` in 1: SPI clock from master, mode 3 (idles high)
- `gsensor_MOSI` in 1: master-out data
- `gsensor_SS_n` in 1: active-low slave select
- `gsensor_MISO` out 1: slave-out data
- `gsensor_MISO_oe` out 1: MISO drive enable (pad tristates when 0)
- `accel_x`, `accel_y`, `accel_z` in 16 each: signed samples
- `accel_valid` in 1: one-cycle strobe, load samples
- `reg_wr_strobe` out 1: one-cycle pulse per accepted write byte
- `reg_wr_addr` out 6: address of the accepted write
- `reg_wr_data` out 8: data of the accepted write
- `xfer_active` out 1: synchronized SS_n is low

## Operation
- SCLK, MOSI and SS_n pass through `SYNC_STAGES` flops.
- SCLK rise/fall are detected from the last two synchronized samples.
- All SPI activity is gated by synchronized SS_n low.
- Mode 3: MOSI is sampled on SCLK rise; MISO is updated on SCLK fall.
- First byte (command), MSB first:
  - bit7 = R/W (1 = read)
  - bit6 = MB (multi-byte)
  - bits5:0 = start address
- FSM states:
  - IDLE → CMD on SS_n fall; bit counter cleared.
  - CMD → DATA after the 8th rise; address register loaded.
  - DATA: repeats 8-bit frames until SS_n rises.
  - Any state → IDLE on SS_n high.
- Read:
  - On the fall following the last command bit, the shift register loads reg[addr].
  - bit7 is driven immediately; the next bit is driven on each subsequent fall.
  - After each byte the next byte is preloaded at the 8th-bit boundary.
- Write:
  - After the 8th rise of a data byte: if the address is writable, reg[addr] ← byte and `reg_wr_strobe` pulses with addr/data for 1 cycle.
  - Writes to read-only addresses are dropped silently, with no strobe.
- Address advance after each data byte:
  - MB=1: addr+1 mod 64 (0x3F wraps to 0x00).
  - MB=0: addr unchanged (same register repeats).
- Read-only addresses:
  - 0x00 = `DEVID`
  - 0x32..0x37 = X0,X1,Y0,Y1,Z0,Z1 (low byte first)
- All other addresses are RAM, reset to 0x00.
- `accel_valid` loads the six data registers from the sample inputs.
- `gsensor_MISO_oe`:
  - 1 only in DATA state of a read transaction.
  - Otherwise 0, with `gsensor_MISO` = 0.
- SS_n rise mid-byte: the partial byte is discarded (no write, no strobe), the FSM goes to IDLE, and `gsensor_MISO_oe` drops.
- Reset mid-transaction: all state clears immediately; the responder ignores the bus until the next SS_n fall.

## Timing
- Reset values:
  - `gsensor_MISO` = 0, `gsensor_MISO_oe` = 0, `reg_wr_strobe` = 0
  - `reg_wr_addr` = 0, `reg_wr_data` = 0, `xfer_active` = 0
  - Synchronizers reset to idle levels (SCLK = 1, SS_n = 1, MOSI = 0).
  - Register file: address 0x00 reads `DEVID`; all others = 0x00.
- Edge-to-action latency is `SYNC_STAGES`+1 clk cycles. This covers:
  - MISO update after an SCLK fall
  - sampling of MOSI after an SCLK rise
  - `reg_wr_strobe` after the 8th rise
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+3 clk cycles; the minimum clk:SCLK ratio is 10:1 at `SYNC_STAGES`=2.
- `xfer_active` follows SS_n with `SYNC_STAGES` cycles latency.
- SS_n fall to first SCLK fall must be ≥ `SYNC_STAGES`+2 cycles.
- `accel_valid` in the same cycle as an SPI preload: the preload sees the old value; the new value is visible from the next byte.

## Configuration
- `GSENSOR_SPI_SNAPSHOT_EN`
- Defined:
  - `accel_valid` while `xfer_active`=1 is captured into a pending buffer; only the latest sample is kept.
  - The pending buffer is copied into 0x32..0x37 one cycle after SS_n deasserts.
  - A multi-byte read of X0..Z1 is therefore coherent.
  - Pending data is discarded on reset.
- Not defined: data registers update on every `accel_valid` regardless of transaction state, and the pending buffer is not built.

## Test plan
- Single read of DEVID: command 0x80, then 8 dummy clocks → MISO returns 0xE5, `gsensor_MISO_oe`=1 only during the data byte.
- Multi-byte read: `accel_x`=0x1234, `accel_y`=0xFF80, `accel_z`=0x0100 with `accel_valid` pulse; command 0xF2 (read, MB, 0x32), 6 bytes → 0x34,0x12,0x80,0xFF,0x00,0x01.
- Write with strobe: command 0x2D, data 0x08 → `reg_wr_strobe` one pulse with addr 0x2D, data 0x08; a subsequent read 0xAD returns 0x08.
- MB write wrap: command 0x7F, data 0xAA,0xBB → 0x3F=0xAA, a second strobe at 0x00 is absent (read-only), and a read of 0x00 still returns 0xE5.
- Abort: SS_n rises after 4 bits of a write data byte → no strobe, register unchanged, `gsensor_MISO_oe`=0.
- Snapshot (macro defined): start read 0xF2, pulse `accel_valid` with X=0x5555 after byte 1 → remaining bytes return the old Y/Z values, and a next read of 0x32 returns 0x55.
